// File: rtl/systolic_feeder.sv
// systolic_feeder: skews X/W operand slices into a ROWS x COLS PE array and sequences one tile.
// Optional build macro FEEDER_PERF_EN adds the stall_cnt output.
module systolic_feeder #(
    parameter int DATA_WIDTH = 32,
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int KW         = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [KW-1:0]              k_len,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ROWS*DATA_WIDTH-1:0] in_x,
    input  logic [COLS*DATA_WIDTH-1:0] in_w,
    output logic [ROWS*DATA_WIDTH-1:0] x_out,
    output logic [COLS*DATA_WIDTH-1:0] w_out,
    output logic                       arr_rst_n,
    output logic                       busy,
    output logic                       done
`ifdef FEEDER_PERF_EN
    ,
    output logic [15:0]                stall_cnt
`endif
);
    localparam int FLUSH_LEN = ROWS + COLS - 1;
    localparam int FW = $clog2(FLUSH_LEN + 1);

    typedef enum logic [2:0] {IDLE, CLEAR, STREAM, FLUSH, DONE} state_t;

    state_t        r_state, w_next;
    logic [KW-1:0] r_k_len, r_cnt;
    logic [FW-1:0] r_flush;
    logic          w_accept, w_last, w_flush_end;

    assign in_ready    = r_state == STREAM;
    assign arr_rst_n   = r_state != CLEAR;
    assign busy        = r_state != IDLE;
    assign done        = r_state == DONE;
    assign w_accept    = in_valid && in_ready;
    // comparing against k_len-1 keeps the counter inside KW bits for k_len = 2^KW-1
    assign w_last      = r_cnt == r_k_len - KW'(1);
    assign w_flush_end = r_flush == FW'(FLUSH_LEN - 1);

    // next-state decode for the tile sequencer
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = (k_len == '0) ? DONE : CLEAR;
            CLEAR:   w_next = STREAM;
            STREAM:  if (w_accept && w_last) w_next = FLUSH;
            FLUSH:   if (w_flush_end) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // state register, latched tile length, slice and flush counters
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_k_len <= '0;
            r_cnt   <= '0;
            r_flush <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && start) begin
                r_k_len <= k_len;
                r_cnt   <= '0;
            end else if (w_accept) begin
                r_cnt <= r_cnt + KW'(1);
            end
            r_flush <= (r_state == FLUSH) ? r_flush + FW'(1) : '0;
        end
    end

    for (genvar i = 0; i < ROWS; i++) begin : g_x
        logic [DATA_WIDTH-1:0] r_sk [0:i];
        // x lane i: i+1 deep free-running chain, bubble (zero) when no slice accepted
        always_ff @(posedge clk) begin
            if (!rst) begin
                for (int s = 0; s <= i; s++) r_sk[s] <= '0;
            end else begin
                r_sk[0] <= w_accept ? in_x[i*DATA_WIDTH +: DATA_WIDTH] : '0;
                for (int s = 1; s <= i; s++) r_sk[s] <= r_sk[s-1];
            end
        end
        assign x_out[i*DATA_WIDTH +: DATA_WIDTH] = r_sk[i];
    end

    for (genvar j = 0; j < COLS; j++) begin : g_w
        logic [DATA_WIDTH-1:0] r_sk [0:j];
        // w lane j: j+1 deep free-running chain, bubble (zero) when no slice accepted
        always_ff @(posedge clk) begin
            if (!rst) begin
                for (int s = 0; s <= j; s++) r_sk[s] <= '0;
            end else begin
                r_sk[0] <= w_accept ? in_w[j*DATA_WIDTH +: DATA_WIDTH] : '0;
                for (int s = 1; s <= j; s++) r_sk[s] <= r_sk[s-1];
            end
        end
        assign w_out[j*DATA_WIDTH +: DATA_WIDTH] = r_sk[j];
    end

`ifdef FEEDER_PERF_EN
    logic [15:0] r_stall;
    // saturating count of STREAM cycles starved by upstream, cleared when a tile enters CLEAR
    always_ff @(posedge clk) begin
        if (!rst)
            r_stall <= '0;
        else if (r_state == IDLE && start && k_len != '0)
            r_stall <= '0;
        else if (r_state == STREAM && !in_valid && r_stall != 16'hFFFF)
            r_stall <= r_stall + 16'd1;
    end
    assign stall_cnt = r_stall;
`endif
endmodule
